ram_port_arbiter: RTL

Arbitrates and sequences access to the single-port synchronous RAM command port between two requesters: the SPI slave command stream and a local parallel host port. SPI address/data command pairs are forwarded atomically under a lock. Host single-beat reads and writes are expanded into the RAM's two-phase command protocol. It sits between the SPI slave, a host bus, and the RAM, replacing the direct slave-to-RAM hookup.

---
 rtl/ram_port_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the RAM command port between the SPI command
// stream and a host port; SPI address/data pairs stay atomic under a lock.
module ram_port_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE+1:0] spi_din,
  input  logic                 spi_valid,
  output logic                 spi_ready,
  output logic [ADDR_SIZE-1:0] spi_dout,
  output logic                 spi_dout_valid,
  input  logic                 host_valid,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [ADDR_SIZE-1:0] host_wdata,
  output logic                 host_ready,
  output logic [ADDR_SIZE-1:0] host_rdata,
  output logic                 host_rvalid,
  output logic                 host_err,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [ADDR_SIZE-1:0] ram_dout,
  input  logic                 ram_tx_valid,
  output logic                 timeout_pulse
);

  localparam int CW = ADDR_SIZE + 2;
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [1:0] OP_WA = 2'b00;
  localparam logic [1:0] OP_WD = 2'b01;
  localparam logic [1:0] OP_RA = 2'b10;
  localparam logic [1:0] OP_RD = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SPI_LOCK,
    SPI_RD_WAIT,
    HOST_A,
    HOST_D,
    HOST_RD_WAIT
  } state_t;

  state_t state, state_nx;

  logic [TW-1:0]        cnt, cnt_nx;
  logic                 last_spi, last_spi_nx;
  logic                 h_we, h_we_nx;
  logic [ADDR_SIZE-1:0] h_wdata, h_wdata_nx;

  logic [CW-1:0]        din_nx;
  logic                 rxv_nx;
  logic [ADDR_SIZE-1:0] sdo_nx;
  logic                 sdv_nx;
  logic [ADDR_SIZE-1:0] hrd_nx;
  logic                 hrv_nx;
  logic                 herr_nx;
  logic                 tp_nx;

  logic       spi_fire;
  logic       host_fire;
  logic       tmo;
  logic [1:0] op;

  assign op = spi_din[CW-1 -: 2];

  // Ready does not depend on the port's own valid, only on the rival's.
  assign spi_ready  = (state == IDLE && (!host_valid || !last_spi))
                   || state == SPI_LOCK;
  assign host_ready = state == IDLE && (!spi_valid || last_spi);

  assign spi_fire  = spi_valid && spi_ready;
  assign host_fire = host_valid && host_ready;
  assign tmo       = cnt == TW'(TIMEOUT - 1);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    last_spi_nx = last_spi;
    h_we_nx     = h_we;
    h_wdata_nx  = h_wdata;
    din_nx      = ram_din;
    rxv_nx      = 1'b0;
    sdo_nx      = spi_dout;
    sdv_nx      = 1'b0;
    hrd_nx      = host_rdata;
    hrv_nx      = 1'b0;
    herr_nx     = 1'b0;
    tp_nx       = 1'b0;
    unique case (state)
      IDLE: begin
        if (spi_fire) begin
          din_nx      = spi_din;
          rxv_nx      = 1'b1;
          last_spi_nx = 1'b1;
          cnt_nx      = '0;
          unique case (op)
            OP_WA, OP_RA: state_nx = SPI_LOCK;
            OP_WD:        state_nx = IDLE;
            OP_RD:        state_nx = SPI_RD_WAIT;
          endcase
        end else if (host_fire) begin
          h_we_nx     = host_we;
          h_wdata_nx  = host_wdata;
          din_nx      = {host_we ? OP_WA : OP_RA, host_addr};
          rxv_nx      = 1'b1;
          last_spi_nx = 1'b0;
          state_nx    = HOST_A;
        end
      end
      SPI_LOCK: begin
        if (spi_fire) begin
          din_nx = spi_din;
          rxv_nx = 1'b1;
          cnt_nx = '0;
          unique case (op)
            OP_WA, OP_RA: state_nx = SPI_LOCK;
            OP_WD:        state_nx = IDLE;
            OP_RD:        state_nx = SPI_RD_WAIT;
          endcase
        end else if (tmo) begin
          tp_nx    = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + TW'(1);
        end
      end
      SPI_RD_WAIT: begin
        if (ram_tx_valid) begin
          sdo_nx   = ram_dout;
          sdv_nx   = 1'b1;
          state_nx = IDLE;
        end else if (tmo) begin
          tp_nx    = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + TW'(1);
        end
      end
      HOST_A: begin
        din_nx   = h_we ? {OP_WD, h_wdata} : {OP_RD, {ADDR_SIZE{1'b0}}};
        rxv_nx   = 1'b1;
        state_nx = HOST_D;
      end
      HOST_D: begin
        cnt_nx   = '0;
        state_nx = h_we ? IDLE : HOST_RD_WAIT;
      end
      HOST_RD_WAIT: begin
        if (ram_tx_valid) begin
          hrd_nx   = ram_dout;
          hrv_nx   = 1'b1;
          state_nx = IDLE;
        end else if (tmo) begin
          hrd_nx   = '0;
          hrv_nx   = 1'b1;
          herr_nx  = 1'b1;
          tp_nx    = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + TW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      last_spi       <= 1'b0;
      h_we           <= 1'b0;
      h_wdata        <= '0;
      ram_din        <= '0;
      ram_rx_valid   <= 1'b0;
      spi_dout       <= '0;
      spi_dout_valid <= 1'b0;
      host_rdata     <= '0;
      host_rvalid    <= 1'b0;
      host_err       <= 1'b0;
      timeout_pulse  <= 1'b0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      last_spi       <= last_spi_nx;
      h_we           <= h_we_nx;
      h_wdata        <= h_wdata_nx;
      ram_din        <= din_nx;
      ram_rx_valid   <= rxv_nx;
      spi_dout       <= sdo_nx;
      spi_dout_valid <= sdv_nx;
      host_rdata     <= hrd_nx;
      host_rvalid    <= hrv_nx;
      host_err       <= herr_nx;
      timeout_pulse  <= tp_nx;
    end
  end

endmodule
